arf066b064e1r1w0cbbehsaa4acw_ctech_sync_bank: RTL and testbench

//  Parametrised multi-bit synchroniser bank for async control inputs to the

---
 rtl/arf066b064e1r1w0cbbehsaa4acw_ctech_sync_bank.sv | 84 ++++++++
 tb/tb_arf066b064e1r1w0cbbehsaa4acw_ctech_sync_bank.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/arf066b064e1r1w0cbbehsaa4acw_ctech_sync_bank.sv
// Multi-bit synchroniser bank for async register-file control strobes.
// Per channel: sync chain, consecutive-cycle glitch filter, registered edge pulses.
module arf066b064e1r1w0cbbehsaa4acw_ctech_sync_bank #(
  parameter int               WIDTH    = 8,
  parameter int               STAGES   = 2,
  parameter logic [WIDTH-1:0] RST_VAL  = '0,
  parameter int               FILT_CNT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_async,
  input  logic             freeze,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             chg_any
);

  localparam int CW = $clog2(FILT_CNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CNT - 1);

  generate
    if (STAGES < 2 || FILT_CNT < 1 || WIDTH < 1) begin : g_bad_param
      $error("sync_bank: illegal parameters (STAGES>=2, FILT_CNT>=1, WIDTH>=1)");
    end
  endgenerate

  logic [WIDTH-1:0] chain [STAGES];
  logic [WIDTH-1:0] s;
  logic [CW-1:0]    cnt      [WIDTH];
  logic [CW-1:0]    cnt_next [WIDTH];
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] rise_next;
  logic [WIDTH-1:0] fall_next;

  // Plain flop-to-flop chain; it keeps shifting even while frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) chain[k] <= RST_VAL;
    end else begin
      chain[0] <= d_async;
      for (int k = 1; k < STAGES; k++) chain[k] <= chain[k-1];
    end
  end

  assign s = chain[STAGES-1];

  always_comb begin
    q_next = q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = cnt[i];
      if (!freeze) begin
        if (s[i] == q[i]) begin
          cnt_next[i] = '0;
        end else if (cnt[i] >= CNT_LAST) begin
          q_next[i]   = s[i];
          cnt_next[i] = '0;
        end else begin
          cnt_next[i] = cnt[i] + CW'(1);
        end
      end
    end
    rise_next = ~q & q_next;
    fall_next = q & ~q_next;
  end

  // Pulses register alongside q, so they mark the first cycle of the new level.
  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= RST_VAL;
      rise    <= '0;
      fall    <= '0;
      chg_any <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      q       <= q_next;
      rise    <= rise_next;
      fall    <= fall_next;
      chg_any <= |(rise_next | fall_next);
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_next[i];
    end
  end

endmodule

// File: tb/tb_arf066b064e1r1w0cbbehsaa4acw_ctech_sync_bank.sv
// Directed bench for the synchroniser bank: reset value, latency, glitch
// rejection, simultaneous edges, freeze hold/resume and mid-filter reset.
module tb_arf066b064e1r1w0cbbehsaa4acw_ctech_sync_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst_a = 1'b1;
  logic [7:0] d_async = 8'hA5;
  logic       freeze = 1'b0;

  logic [7:0] q, rise, fall;
  logic       chg_any;
  logic [7:0] q_a, rise_a, fall_a;
  logic       chg_any_a;

  int vectors = 0;
  int miscompares = 0;

  logic       mon_en = 1'b0;
  logic       overlap_seen = 1'b0;
  logic [7:0] q_prev;
  int         pulse_total = 0;
  int         trans_total = 0;

  always #5 clk = ~clk;

  arf066b064e1r1w0cbbehsaa4acw_ctech_sync_bank dut (
    .clk(clk), .rst(rst), .d_async(d_async), .freeze(freeze),
    .q(q), .rise(rise), .fall(fall), .chg_any(chg_any)
  );

  arf066b064e1r1w0cbbehsaa4acw_ctech_sync_bank #(.RST_VAL(8'hA5)) dut_a5 (
    .clk(clk), .rst(rst_a), .d_async(d_async), .freeze(freeze),
    .q(q_a), .rise(rise_a), .fall(fall_a), .chg_any(chg_any_a)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse bookkeeping on the falling edge, away from the update edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if ((rise & fall) != 8'h00) overlap_seen = 1'b1;
      pulse_total += $countones(rise | fall);
      trans_total += $countones(q ^ q_prev);
      q_prev = q;
    end
  end

  initial begin
    int n;

    // 1: non-zero reset value, nothing pulses during or after reset
    tick(1);
    chk("t1_rst_q", q_a, 8'hA5);
    chk("t1_rst_pulse", {rise_a, fall_a, 7'd0, chg_any_a}, 32'd0);
    tick(2);
    chk("t1_rst_q3", q_a, 8'hA5);
    rst_a = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("t1_rel_q", q_a, 8'hA5);
      chk("t1_rel_pulse", {rise_a, fall_a, 7'd0, chg_any_a}, 32'd0);
    end

    // 2: single rising channel, latency STAGES+FILT_CNT = 5 edges
    d_async = 8'h00;
    tick(3);
    rst = 1'b0;
    tick(2);
    chk("t2_idle_q", q, 8'h00);
    chk("t2_idle_chg", chg_any, 1'b0);
    q_prev = q;
    mon_en = 1'b1;
    d_async = 8'h01;
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      chk("t2_wait_q", q, 8'h00);
    end
    tick(1);
    chk("t2_q", q, 8'h01);
    chk("t2_rise", rise, 8'h01);
    chk("t2_fall", fall, 8'h00);
    chk("t2_chg", chg_any, 1'b1);
    tick(1);
    chk("t2_rise_end", rise, 8'h00);
    chk("t2_chg_end", chg_any, 1'b0);

    // 3: two-cycle glitch on bit 1 is discarded
    d_async = 8'h03;
    tick(2);
    d_async = 8'h01;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("t3_q", q, 8'h01);
      chk("t3_chg", {rise, fall, 7'd0, chg_any}, 32'd0);
    end

    // 4: simultaneous rise on bit 7 and fall on bit 0
    d_async = 8'h80;
    tick(4);
    chk("t4_pre_q", q, 8'h01);
    tick(1);
    chk("t4_q", q, 8'h80);
    chk("t4_rise", rise, 8'h80);
    chk("t4_fall", fall, 8'h01);
    chk("t4_chg", chg_any, 1'b1);
    tick(1);
    chk("t4_chg_end", chg_any, 1'b0);

    // 5: freeze after one filter count, resume needs FILT_CNT-1 = 2 edges
    d_async = 8'h00;
    tick(8);
    chk("t5_base_q", q, 8'h00);
    d_async = 8'h01;
    tick(3);
    freeze = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("t5_frz_q", q, 8'h00);
      chk("t5_frz_chg", chg_any, 1'b0);
    end
    freeze = 1'b0;
    tick(1);
    chk("t5_rel1_q", q, 8'h00);
    tick(1);
    chk("t5_rel2_q", q, 8'h01);
    chk("t5_rise", rise, 8'h01);
    tick(1);
    chk("t5_rise_end", rise, 8'h00);

    // 6: reset mid-filter drops the pending count; chain restarts from reset value
    d_async = 8'h00;
    tick(8);
    chk("t6_base_q", q, 8'h00);
    d_async = 8'hFF;
    tick(3);
    rst = 1'b1;
    tick(1);
    chk("t6_rst_q", q, 8'h00);
    chk("t6_rst_pulse", {rise, fall, 7'd0, chg_any}, 32'd0);
    rst = 1'b0;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (q !== 8'hFF && n < 20);
    chk("t6_relat", n, 5);
    chk("t6_rise", rise, 8'hFF);
    chk("t6_fall", fall, 8'h00);
    tick(1);
    chk("t6_rise_end", rise, 8'h00);

    // global pulse invariants
    tick(2);
    mon_en = 1'b0;
    chk("overlap", overlap_seen, 1'b0);
    chk("pulse_vs_trans", pulse_total, trans_total);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
